// File: rtl/reg_scoreboard_if.sv
// Decode/writeback bundle for the register scoreboard.
// Master drives requests; slave returns read data and hazards.
interface reg_scoreboard_if #(
    parameter int DW = 32
);
    logic          issue_valid;
    logic          issue_wen;
    logic [4:0]    issue_dst;
    logic [4:0]    rs_addr;
    logic [4:0]    rt_addr;
    logic          wb_we;
    logic [4:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic          stall;
    logic          busy;

    modport master (
        output issue_valid, issue_wen, issue_dst,
        output rs_addr, rt_addr,
        output wb_we, wb_addr, wb_data, flush,
        input  rs_data, rt_data, stall, busy
    );

    modport slave (
        input  issue_valid, issue_wen, issue_dst,
        input  rs_addr, rt_addr,
        input  wb_we, wb_addr, wb_data, flush,
        output rs_data, rt_data, stall, busy
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register file with bypass plus per-register pending-write
// counters that stall decode on RAW hazards and counter overflow.
module reg_scoreboard #(
    parameter int NREG = 32,
    parameter int DW   = 32,
    parameter int CW   = 2
) (
    input logic          clock,
    input logic          reset,
    reg_scoreboard_if.slave bus
);
    localparam logic [CW-1:0] PMAX = {CW{1'b1}};
    localparam logic [CW-1:0] PONE = CW'(1);

    logic [DW-1:0] regs_q [NREG];
    logic [CW-1:0] pend_q [NREG];
    logic [CW-1:0] pend_d [NREG];
    logic [CW-1:0] pv     [NREG];

    logic rs_fwd, rt_fwd;
    logic hz_rs, hz_rt, dst_full;
    logic stall, acc, busy;

    // Reset forces the visible state to the cleared view.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pv[r] = (reset || r == 0) ? '0 : pend_q[r];
        end
    end

    assign rs_fwd = bus.wb_we && (bus.wb_addr == bus.rs_addr);
    assign rt_fwd = bus.wb_we && (bus.wb_addr == bus.rt_addr);

    assign bus.rs_data = (bus.rs_addr == 5'd0) ? '0 :
                         rs_fwd ? bus.wb_data :
                         reset  ? '0 : regs_q[bus.rs_addr];
    assign bus.rt_data = (bus.rt_addr == 5'd0) ? '0 :
                         rt_fwd ? bus.wb_data :
                         reset  ? '0 : regs_q[bus.rt_addr];

    // A last outstanding write landing now is covered by bypass.
    assign hz_rs = (bus.rs_addr != 5'd0) &&
                   (pv[bus.rs_addr] != '0) &&
                   !(rs_fwd && pv[bus.rs_addr] == PONE);
    assign hz_rt = (bus.rt_addr != 5'd0) &&
                   (pv[bus.rt_addr] != '0) &&
                   !(rt_fwd && pv[bus.rt_addr] == PONE);

    assign dst_full = bus.issue_wen &&
                      (bus.issue_dst != 5'd0) &&
                      (pv[bus.issue_dst] == PMAX) &&
                      !(bus.wb_we && bus.wb_addr == bus.issue_dst);

    assign stall = bus.issue_valid && !bus.flush &&
                   (hz_rs || hz_rt || dst_full);
    assign acc   = bus.issue_valid && !stall && !bus.flush;
    assign bus.stall = stall;

    // Next pending count: +1 on issue, -1 on writeback, flush clears.
    always_comb begin
        logic inc, dec;
        pend_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            inc = acc && bus.issue_wen &&
                  (bus.issue_dst == 5'(r));
            dec = bus.wb_we && (bus.wb_addr == 5'(r)) &&
                  (pend_q[r] != '0);
            pend_d[r] = pend_q[r];
            if (bus.flush)
                pend_d[r] = '0;
            else if (inc && !dec)
                pend_d[r] = pend_q[r] + PONE;
            else if (dec && !inc)
                pend_d[r] = pend_q[r] - PONE;
        end
    end

    // Busy reflects registered counters only.
    always_comb begin
        busy = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            busy = busy | (pend_q[r] != '0);
        end
    end
    assign bus.busy = busy;

    // Register file write port and counter state.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
        end else begin
            if (bus.wb_we && bus.wb_addr != 5'd0)
                regs_q[bus.wb_addr] <= bus.wb_data;
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= pend_d[r];
            end
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic
// compared against an arithmetic scoreboard model.
module tb_reg_scoreboard;
    logic clock;
    logic reset;
    int   nchk;
    int   npass;

    int          m_pend [32];
    logic [31:0] m_regs [32];

    reg_scoreboard_if #(.DW(32)) bus ();

    reg_scoreboard #(
        .NREG(32), .DW(32), .CW(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic int mp(input logic [4:0] a);
        if (reset || a == 0) return 0;
        return m_pend[a];
    endfunction

    function automatic logic [31:0] mrd(input logic [4:0] a);
        if (a == 0) return 0;
        if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
        if (reset) return 0;
        return m_regs[a];
    endfunction

    function automatic logic mhz(input logic [4:0] a);
        logic done_now;
        if (a == 0 || mp(a) == 0) return 0;
        done_now = bus.wb_we && bus.wb_addr == a && mp(a) == 1;
        return !done_now;
    endfunction

    function automatic logic mstall();
        logic full;
        full = bus.issue_wen && bus.issue_dst != 0 &&
               mp(bus.issue_dst) == 3 &&
               !(bus.wb_we && bus.wb_addr == bus.issue_dst);
        return bus.issue_valid && !bus.flush &&
               (mhz(bus.rs_addr) || mhz(bus.rt_addr) || full);
    endfunction

    function automatic logic mbusy();
        for (int r = 0; r < 32; r++)
            if (m_pend[r] != 0) return 1;
        return 0;
    endfunction

    task automatic drive(input logic v, input logic wen,
                         input logic [4:0] dst,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic we, input logic [4:0] wa,
                         input logic [31:0] wd,
                         input logic fl, input logic rst);
        bus.issue_valid = v;
        bus.issue_wen   = wen;
        bus.issue_dst   = dst;
        bus.rs_addr     = rs;
        bus.rt_addr     = rt;
        bus.wb_we       = we;
        bus.wb_addr     = wa;
        bus.wb_data     = wd;
        bus.flush       = fl;
        reset           = rst;
        #1;
        chk("rs_data", bus.rs_data, mrd(rs));
        chk("rt_data", bus.rt_data, mrd(rt));
        chk("stall", 32'(bus.stall), 32'(mstall()));
        chk("busy", 32'(bus.busy), 32'(mbusy()));
    endtask

    task automatic tick();
        logic acc;
        int   d, w;
        @(posedge clock);
        acc = bus.issue_valid && !bus.flush && !mstall();
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 0;
                m_pend[r] = 0;
            end
        end else begin
            if (bus.wb_we && bus.wb_addr != 0)
                m_regs[bus.wb_addr] = bus.wb_data;
            if (bus.flush) begin
                for (int r = 0; r < 32; r++) m_pend[r] = 0;
            end else begin
                d = (acc && bus.issue_wen && bus.issue_dst != 0)
                    ? int'(bus.issue_dst) : -1;
                w = (bus.wb_we && bus.wb_addr != 0 &&
                     m_pend[bus.wb_addr] > 0)
                    ? int'(bus.wb_addr) : -1;
                if (d != w) begin
                    if (d > 0) m_pend[d] = m_pend[d] + 1;
                    if (w > 0) m_pend[w] = m_pend[w] - 1;
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        nchk  = 0;
        npass = 0;
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 0;
            m_pend[r] = 0;
        end
        @(negedge clock);
        drive(1, 1, 3, 0, 0, 1, 6, 32'h55, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);      tick();
        idle();
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        tick();

        drive(0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0); tick();
        drive(0, 0, 0, 5, 5, 0, 0, 0, 0, 0);
        chk("wr_rd", bus.rs_data, 32'hDEADBEEF);
        tick();
        drive(0, 0, 0, 4, 5, 1, 5, 32'hDEADBEEF, 0, 0);
        chk("byp_rt", bus.rt_data, 32'hDEADBEEF);
        tick();

        drive(0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0); tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_rd", bus.rs_data, 0);
        tick();
        idle();
        chk("r0_busy", 32'(bus.busy), 0);
        tick();

        drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 7, 0, 0, 0, 0, 0, 0);
        chk("raw_stall", 32'(bus.stall), 1);
        drive(1, 0, 0, 7, 0, 1, 7, 32'hA5A5, 0, 0);
        chk("raw_byp", 32'(bus.stall), 0);
        chk("raw_data", bus.rs_data, 32'hA5A5);
        tick();
        idle();
        chk("raw_clr", 32'(bus.busy), 0);
        tick();

        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0); tick();
        end
        drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_stall", 32'(bus.stall), 1);
        drive(1, 1, 9, 0, 0, 1, 9, 32'h9, 0, 0);
        chk("sat_wb", 32'(bus.stall), 0);
        tick();
        drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_hold", 32'(bus.stall), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();

        drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 4, 0, 0, 1, 4, 32'h44, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 12, 32'hC, 0, 0); tick();
        drive(1, 0, 0, 4, 12, 0, 0, 0, 0, 0);
        chk("sim_p4", 32'(bus.stall), 1);
        drive(1, 0, 0, 12, 0, 0, 0, 0, 0, 0);
        chk("sim_p12", 32'(bus.stall), 0);
        drive(0, 0, 0, 0, 0, 1, 4, 32'h44, 0, 0); tick();

        drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 8, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        drive(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        chk("fl_busy", 32'(bus.busy), 0);
        chk("fl_stall", 32'(bus.stall), 0);
        tick();
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 8, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drive(1, 0, 0, 5, 7, 0, 0, 0, 0, 0);
        chk("rs_rst_busy", 32'(bus.busy), 0);
        chk("rs_rst_r5", bus.rs_data, 0);
        tick();

        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)),
                  $urandom,
                  $urandom_range(0, 24) == 0,
                  $urandom_range(0, 60) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): NREG, 32, architectural register count; DW, 32, data width; CW, 2, per-register pending-counter width.
REQ-002 Port clock, input, 1: rising-edge clock for all state.
REQ-003 Port reset, input, 1: reset signal, synchronous, active-high.
REQ-004 Port issue_valid, input, 1: decode stage presents an instruction this cycle.
REQ-005 Port issue_wen, input, 1: the presented instruction writes a destination register.
REQ-006 Port issue_dst, input, 5: destination register address.
REQ-007 Port rs_addr, input, 5: source A register address.
REQ-008 Port rt_addr, input, 5: source B register address.
REQ-009 Port wb_we, input, 1: writeback-stage write enable (regwrite from the writeback pipeline register).
REQ-010 Port wb_addr, input, 5: writeback destination register address.
REQ-011 Port wb_data, input, DW: writeback data.
REQ-012 Port flush, input, 1: pipeline flush; cancels the issue this cycle and clears the scoreboard.
REQ-013 Port rs_data, output, DW: source A read data, combinational.
REQ-014 Port rt_data, output, DW: source B read data, combinational.
REQ-015 Port stall, output, 1: decode SHALL hold; the issue is not accepted this cycle.
REQ-016 Port busy, output, 1: high when any pending counter is nonzero.

Function
REQ-017 The register file SHALL be NREG x DW, with one synchronous write port and two combinational read ports.
REQ-018 Register 0 SHALL always read 0; writes to address 0 SHALL be ignored.
REQ-019 The write SHALL occur at the clock edge when wb_we=1 and wb_addr!=0.
REQ-020 Read bypass: when wb_we=1 and wb_addr==rs_addr!=0, rs_data SHALL equal wb_data in the same cycle. rt_data SHALL bypass the same way.
REQ-021 Each register SHALL have a CW-bit pending counter pend[r]; pend[0] SHALL be constant 0.
REQ-022 The issue SHALL be accepted (acc=1) when issue_valid=1, stall=0 and flush=0.
REQ-023 inc[r] SHALL be 1 when acc=1, issue_wen=1, issue_dst==r and r!=0.
REQ-024 dec[r] SHALL be 1 when wb_we=1, wb_addr==r, r!=0 and pend[r]!=0. A writeback to a register whose counter is 0 SHALL NOT change the counter (no underflow).
REQ-025 Counter update each edge: inc&!dec gives +1; dec&!inc gives -1; inc&dec or neither leaves it unchanged.
REQ-026 Source hazard hz(a) SHALL be 1 when a!=0, pend[a]!=0, and not (wb_we=1, wb_addr==a and pend[a]==1). A last outstanding write completing this cycle is covered by the bypass.
REQ-027 stall SHALL equal issue_valid & !flush & (hz(rs_addr) | hz(rt_addr) | dst_full).
REQ-028 dst_full SHALL be 1 when issue_wen=1, issue_dst!=0 and pend[issue_dst] is at its maximum (2^CW-1). It SHALL be 0 if a same-register dec occurs in this cycle.
REQ-029 stall SHALL be combinational, with zero-cycle latency. An accepted issue SHALL be reflected in pend on the next cycle.
REQ-030 When flush=1, all pend[r] SHALL clear to 0 at the edge, overriding inc/dec.
REQ-031 Register data writes SHALL proceed normally during flush.
REQ-032 busy SHALL be the OR of all pend[r], registered state only.

Reset
REQ-033 While reset=1 at the edge, all registers SHALL be set to 0 and all pend SHALL be set to 0.
REQ-034 After reset, stall SHALL be 0 and busy SHALL be 0.
REQ-035 Reset SHALL override flush, issue and writeback in the same cycle; a mid-operation reset discards all pending state.
REQ-036 While reset=1, outputs SHALL still follow REQ-020 and REQ-027 from the cleared state, with rs_data=rt_data=0 unless bypassed.

Verification
REQ-037 Write then read: wb_we=1, wb_addr=5, wb_data=0xDEADBEEF; next cycle rs_addr=5 gives rs_data=0xDEADBEEF. In the same cycle, rt_addr=5 gives bypassed 0xDEADBEEF.
REQ-038 R0: wb_we=1, wb_addr=0, wb_data=0xFFFFFFFF; next cycle rs_addr=0 gives rs_data=0. Issue with dst=0 leaves busy=0.
REQ-039 RAW stall: accept issue dst=7; next cycle issue rs=7 gives stall=1. With wb_we=1, wb_addr=7 that cycle: stall=0, rs_data=wb_data, pend[7]=0 afterward.
REQ-040 Saturation: three accepted issues to dst=9 give pend=3. A fourth issue to dst=9 gives stall=1. If a wb to 9 occurs in the same cycle: stall=0 and pend stays 3.
REQ-041 Simultaneous events: pend[4]=1, accepted issue dst=4 together with wb to 4 gives pend[4]=1 next cycle. A wb to 12 with pend[12]=0 keeps pend[12]=0.
REQ-042 Flush/reset: pend[3]=2, pend[8]=1, flush=1 gives busy=0 next cycle and issue rs=3 gives no stall. Repeating with reset=1 additionally gives all registers 0.
